// File: rtl/mat_mul_sat_if.sv
// Stream bundle for mat_mul_sat: the operand input stream (s00) and the result output stream (m00).
interface mat_mul_sat_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    s00_axis_tready;
  logic                    s00_axis_tvalid;
  logic                    s00_axis_tlast;
  logic [DATA_WIDTH-1:0]   s00_axis_tdata;
  logic                    m00_axis_tready;
  logic                    m00_axis_tvalid;
  logic                    m00_axis_tlast;
  logic [DATA_WIDTH-1:0]   m00_axis_tdata;
  logic [DATA_WIDTH/8-1:0] m00_axis_tstrb;

  // Block view: sinks operands, sources results.
  modport slave (
    output s00_axis_tready,
    input  s00_axis_tvalid,
    input  s00_axis_tlast,
    input  s00_axis_tdata,
    input  m00_axis_tready,
    output m00_axis_tvalid,
    output m00_axis_tlast,
    output m00_axis_tdata,
    output m00_axis_tstrb
  );

  // Environment view: sources operands, sinks results.
  modport master (
    input  s00_axis_tready,
    output s00_axis_tvalid,
    output s00_axis_tlast,
    output s00_axis_tdata,
    output m00_axis_tready,
    input  m00_axis_tvalid,
    input  m00_axis_tlast,
    input  m00_axis_tdata,
    input  m00_axis_tstrb
  );
endinterface

// File: rtl/mat_mul_sat.sv
// Square DIM x DIM matrix multiplier R = A x B with a wide accumulator and saturating write-back.
// A then B arrive on one input stream; R leaves on an output stream with full backpressure.
module mat_mul_sat #(
  parameter int DIM        = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
  input  logic         s00_axi_aclk,
  input  logic         s00_axi_areset,
  mat_mul_sat_if.slave axis,
  input  logic         start,
  input  logic         signed_mode,
  output logic         done,
  output logic         ovf,
  output logic         err
);
  localparam int SIZE     = DIM*DIM;
  localparam int ADDR_W   = $clog2(SIZE);
  localparam int CNT_W    = $clog2(DIM);
  localparam int CYC_LAST = DIM*DIM*DIM + 2;
  localparam int CYC_W    = $clog2(CYC_LAST + 1);

  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(SIZE-1);
  localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(DIM-1);
  localparam logic [CYC_W-1:0]     CYC_END   = CYC_W'(CYC_LAST);
  localparam logic [ACC_WIDTH-1:0] SMAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] UMAX = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    READY   = 3'd2,
    COMPUTE = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  // Extend both operands to the accumulator width, then multiply; the low ACC_WIDTH
  // bits of the product are exact in either mode because ACC_WIDTH >= 2*DATA_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] mac_product(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic                  sgn
  );
    logic [ACC_WIDTH-1:0] ea;
    logic [ACC_WIDTH-1:0] eb;
    ea = sgn ? {{(ACC_WIDTH-DATA_WIDTH){a[DATA_WIDTH-1]}}, a} : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, a};
    eb = sgn ? {{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b} : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, b};
    return ea * eb;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [DATA_WIDTH:0] saturate(
    input logic [ACC_WIDTH-1:0] acc,
    input logic                 sgn
  );
    logic [DATA_WIDTH:0] res;
    if (sgn) begin
      if ($signed(acc) > $signed(SMAX)) begin
        res = {1'b1, SMAX[DATA_WIDTH-1:0]};
      end else if ($signed(acc) < $signed(SMIN)) begin
        res = {1'b1, SMIN[DATA_WIDTH-1:0]};
      end else begin
        res = {1'b0, acc[DATA_WIDTH-1:0]};
      end
    end else begin
      if (acc > UMAX) begin
        res = {1'b1, UMAX[DATA_WIDTH-1:0]};
      end else begin
        res = {1'b0, acc[DATA_WIDTH-1:0]};
      end
    end
    return res;
  endfunction

  state_t                state_r;
  state_t                next_state_s;
  logic                  tready_r;
  logic [ADDR_W-1:0]     load_cnt_r;
  logic                  err_r;
  logic                  frame_err_s;
  logic                  in_hs_s;
  logic                  load_last_s;
  logic                  start_ok_s;

  logic [DATA_WIDTH-1:0] mem_a [SIZE];
  logic [DATA_WIDTH-1:0] mem_b [SIZE];
  logic [DATA_WIDTH-1:0] mem_r [SIZE];

  logic                  mode_r;
  logic                  issue_r;
  logic [CNT_W-1:0]      row_r;
  logic [CNT_W-1:0]      col_r;
  logic [CNT_W-1:0]      k_r;
  logic [CYC_W-1:0]      cyc_r;
  logic [ADDR_W-1:0]     addr_a_s;
  logic [ADDR_W-1:0]     addr_b_s;
  logic [ADDR_W-1:0]     idx_s;
  logic [DATA_WIDTH-1:0] a_rd_r;
  logic [DATA_WIDTH-1:0] b_rd_r;
  logic                  s2_valid_r;
  logic                  s2_first_r;
  logic                  s2_last_r;
  logic [ADDR_W-1:0]     s2_idx_r;
  logic                  s3_valid_r;
  logic [ADDR_W-1:0]     s3_idx_r;
  logic [ACC_WIDTH-1:0]  acc_r;
  logic [DATA_WIDTH:0]   sat_s;
  logic                  ovf_r;

  logic                  tvalid_r;
  logic                  tlast_r;
  logic [DATA_WIDTH-1:0] tdata_r;
  logic [ADDR_W-1:0]     out_idx_r;
  logic [ADDR_W-1:0]     out_nxt_s;
  logic                  out_hs_s;
  logic                  done_r;

  assign in_hs_s     = tready_r & axis.s00_axis_tvalid;
  assign out_hs_s    = tvalid_r & axis.m00_axis_tready;
  assign load_last_s = (load_cnt_r == LAST_ADDR);
  assign start_ok_s  = (state_r == READY) & start;
  assign addr_a_s    = ADDR_W'(row_r) * ADDR_W'(DIM) + ADDR_W'(k_r);
  assign addr_b_s    = ADDR_W'(k_r) * ADDR_W'(DIM) + ADDR_W'(col_r);
  assign idx_s       = ADDR_W'(row_r) * ADDR_W'(DIM) + ADDR_W'(col_r);
  assign sat_s       = saturate(acc_r, mode_r);
  assign out_nxt_s   = out_idx_r + ADDR_W'(1);

  assign axis.s00_axis_tready = tready_r;
  assign axis.m00_axis_tvalid = tvalid_r;
  assign axis.m00_axis_tlast  = tlast_r;
  assign axis.m00_axis_tdata  = tdata_r;
  assign axis.m00_axis_tstrb  = {(DATA_WIDTH/8){1'b1}};
  assign done = done_r;
  assign ovf  = ovf_r;
  assign err  = err_r;

  // Next-state decode and framing check.
  always_comb begin
    next_state_s = state_r;
    frame_err_s  = 1'b0;
    case (state_r)
      LOAD_A: begin
        if (in_hs_s) begin
          if (axis.s00_axis_tlast) begin
            frame_err_s  = 1'b1;
            next_state_s = LOAD_A;
          end else if (load_last_s) begin
            next_state_s = LOAD_B;
          end else begin
            next_state_s = LOAD_A;
          end
        end else begin
          next_state_s = LOAD_A;
        end
      end
      LOAD_B: begin
        if (in_hs_s) begin
          if (axis.s00_axis_tlast != load_last_s) begin
            frame_err_s  = 1'b1;
            next_state_s = LOAD_A;
          end else if (load_last_s) begin
            next_state_s = READY;
          end else begin
            next_state_s = LOAD_B;
          end
        end else begin
          next_state_s = LOAD_B;
        end
      end
      READY: begin
        if (start) begin
          next_state_s = COMPUTE;
        end else begin
          next_state_s = READY;
        end
      end
      COMPUTE: begin
        if (cyc_r == CYC_END) begin
          next_state_s = OUTPUT;
        end else begin
          next_state_s = COMPUTE;
        end
      end
      OUTPUT: begin
        if (out_hs_s && tlast_r) begin
          next_state_s = LOAD_A;
        end else begin
          next_state_s = OUTPUT;
        end
      end
      default: begin
        next_state_s = LOAD_A;
      end
    endcase
  end

  // State register, input-side ready, load counter and sticky framing error.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      state_r    <= LOAD_A;
      tready_r   <= 1'b1;
      load_cnt_r <= {ADDR_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      tready_r <= (next_state_s == LOAD_A) || (next_state_s == LOAD_B);
      if (frame_err_s) begin
        err_r <= 1'b1;
      end
      if (in_hs_s) begin
        load_cnt_r <= (frame_err_s || load_last_s) ? {ADDR_W{1'b0}} : load_cnt_r + ADDR_W'(1);
      end
    end
  end

  // Operand/result storage with registered operand reads; contents need no reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (in_hs_s && (state_r == LOAD_A)) begin
      mem_a[load_cnt_r] <= axis.s00_axis_tdata;
    end
    if (in_hs_s && (state_r == LOAD_B)) begin
      mem_b[load_cnt_r] <= axis.s00_axis_tdata;
    end
    if (s3_valid_r) begin
      mem_r[s3_idx_r] <= sat_s[DATA_WIDTH-1:0];
    end
    a_rd_r <= mem_a[addr_a_s];
    b_rd_r <= mem_b[addr_b_s];
  end

  // MAC issue counters (row, col, k innermost), pipeline tags and accumulator.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      mode_r     <= 1'b0;
      issue_r    <= 1'b0;
      row_r      <= {CNT_W{1'b0}};
      col_r      <= {CNT_W{1'b0}};
      k_r        <= {CNT_W{1'b0}};
      cyc_r      <= {CYC_W{1'b0}};
      s2_valid_r <= 1'b0;
      s2_first_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_idx_r   <= {ADDR_W{1'b0}};
      s3_valid_r <= 1'b0;
      s3_idx_r   <= {ADDR_W{1'b0}};
      acc_r      <= {ACC_WIDTH{1'b0}};
    end else begin
      if (start_ok_s) begin
        mode_r  <= signed_mode;
        issue_r <= 1'b1;
        row_r   <= {CNT_W{1'b0}};
        col_r   <= {CNT_W{1'b0}};
        k_r     <= {CNT_W{1'b0}};
        cyc_r   <= {CYC_W{1'b0}};
      end else if (state_r == COMPUTE) begin
        cyc_r <= cyc_r + CYC_W'(1);
        if (issue_r) begin
          if (k_r == LAST_CNT) begin
            k_r <= {CNT_W{1'b0}};
            if (col_r == LAST_CNT) begin
              col_r <= {CNT_W{1'b0}};
              if (row_r == LAST_CNT) begin
                row_r   <= {CNT_W{1'b0}};
                issue_r <= 1'b0;
              end else begin
                row_r <= row_r + CNT_W'(1);
              end
            end else begin
              col_r <= col_r + CNT_W'(1);
            end
          end else begin
            k_r <= k_r + CNT_W'(1);
          end
        end
      end
      s2_valid_r <= (state_r == COMPUTE) && issue_r;
      s2_first_r <= (k_r == {CNT_W{1'b0}});
      s2_last_r  <= (k_r == LAST_CNT);
      s2_idx_r   <= idx_s;
      s3_valid_r <= s2_valid_r && s2_last_r;
      s3_idx_r   <= s2_idx_r;
      if (s2_valid_r) begin
        acc_r <= (s2_first_r ? {ACC_WIDTH{1'b0}} : acc_r) + mac_product(a_rd_r, b_rd_r, mode_r);
      end
    end
  end

  // Sticky saturation flag, cleared when a new multiply starts.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      ovf_r <= 1'b0;
    end else if (start_ok_s) begin
      ovf_r <= 1'b0;
    end else if (s3_valid_r && sat_s[DATA_WIDTH]) begin
      ovf_r <= 1'b1;
    end
  end

  // Result streaming: the next element is fetched on each handshake, giving zero bubbles.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      tvalid_r  <= 1'b0;
      tlast_r   <= 1'b0;
      tdata_r   <= {DATA_WIDTH{1'b0}};
      out_idx_r <= {ADDR_W{1'b0}};
      done_r    <= 1'b0;
    end else begin
      done_r <= out_hs_s && tlast_r;
      if (state_r == OUTPUT) begin
        if (!tvalid_r) begin
          tvalid_r  <= 1'b1;
          tdata_r   <= mem_r[{ADDR_W{1'b0}}];
          tlast_r   <= 1'b0;
          out_idx_r <= {ADDR_W{1'b0}};
        end else if (out_hs_s) begin
          if (tlast_r) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
          end else begin
            out_idx_r <= out_nxt_s;
            tdata_r   <= mem_r[out_nxt_s];
            tlast_r   <= (out_nxt_s == LAST_ADDR);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mat_mul_sat.sv
// Randomized bench for mat_mul_sat (DIM=3, 8-bit elements) against a plain integer matrix model.
module tb_mat_mul_sat;
  localparam int DIM = 3;
  localparam int DW  = 8;
  localparam int SZ  = DIM*DIM;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed_mode = 1'b0;
  logic done;
  logic ovf;
  logic err;

  int vectors = 0;
  int miscompares = 0;
  int a_m [SZ];
  int b_m [SZ];
  int exp_r [SZ];

  mat_mul_sat_if #(.DATA_WIDTH(DW)) axis ();

  mat_mul_sat #(.DIM(DIM), .DATA_WIDTH(DW), .ACC_WIDTH(2*DW+8)) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .axis           (axis),
    .start          (start),
    .signed_mode    (signed_mode),
    .done           (done),
    .ovf            (ovf),
    .err            (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input longint got, input longint expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int elem(input int raw, input bit sg);
    return (sg && raw > 127) ? raw - 256 : raw;
  endfunction

  // Reference: R = A x B in plain integers, then clamp to the element range.
  task automatic model(input bit sg, output bit ovf_e);
    int s;
    int lo;
    int hi;
    ovf_e = 1'b0;
    lo = sg ? -128 : 0;
    hi = sg ? 127 : 255;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        s = 0;
        for (int k = 0; k < DIM; k++) s += elem(a_m[i*DIM+k], sg) * elem(b_m[k*DIM+j], sg);
        if (s > hi) begin s = hi; ovf_e = 1'b1; end
        else if (s < lo) begin s = lo; ovf_e = 1'b1; end
        exp_r[i*DIM+j] = s & 255;
      end
    end
  endtask

  task automatic send_word(input int d, input bit last, input bit st);
    int g;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    axis.s00_axis_tvalid = 1'b1;
    axis.s00_axis_tdata  = 8'(d);
    axis.s00_axis_tlast  = last;
    start = st;
    g = 0;
    while (!axis.s00_axis_tready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check_eq("in_ready_timeout", g, 0);
    @(negedge clk);
    axis.s00_axis_tvalid = 1'b0;
    axis.s00_axis_tlast  = 1'b0;
    start = 1'b0;
  endtask

  task automatic load_ab(input bit b_last_ok, input bit start_on_last);
    for (int i = 0; i < SZ; i++) send_word(a_m[i], 1'b0, 1'b0);
    for (int i = 0; i < SZ; i++) send_word(b_m[i], (i == SZ-1) && b_last_ok, start_on_last && (i == SZ-1));
  endtask

  // Pulse start, then drain R under a tready pattern: 0 = always 1, 1 = 1,0,0 repeating, 2 = random.
  task automatic run_mult(input bit mode, input int pat);
    bit ovf_e;
    bit tr;
    bit stalled;
    logic [7:0] held_d;
    logic held_l;
    int got_n;
    int first_v;
    int last_hs;
    model(mode, ovf_e);
    check_eq("ready_state_tready", axis.s00_axis_tready, 0);
    start = 1'b1;
    signed_mode = mode;
    @(negedge clk);
    start = 1'b0;
    signed_mode = ~mode;
    got_n = 0;
    stalled = 1'b0;
    first_v = -1;
    last_hs = -1;
    held_d = 8'd0;
    held_l = 1'b0;
    for (int e = 0; e < 600 && got_n < SZ; e++) begin
      if (axis.m00_axis_tvalid && first_v < 0) first_v = e;
      if (stalled) begin
        check_eq("stall_valid", axis.m00_axis_tvalid, 1);
        check_eq("stall_data", axis.m00_axis_tdata, held_d);
        check_eq("stall_last", axis.m00_axis_tlast, held_l);
      end
      case (pat)
        0:       tr = 1'b1;
        1:       tr = (e % 3 == 0);
        default: tr = 1'($urandom_range(0, 1));
      endcase
      axis.m00_axis_tready = tr;
      if (axis.m00_axis_tvalid && tr) begin
        check_eq($sformatf("r%0d_data", got_n), axis.m00_axis_tdata, exp_r[got_n]);
        check_eq($sformatf("r%0d_last", got_n), axis.m00_axis_tlast, (got_n == SZ-1) ? 1 : 0);
        check_eq("done_early", done, 0);
        got_n++;
        last_hs = e;
        stalled = 1'b0;
      end else if (axis.m00_axis_tvalid) begin
        stalled = 1'b1;
        held_d = axis.m00_axis_tdata;
        held_l = axis.m00_axis_tlast;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("out_count", got_n, SZ);
    check_eq("first_valid_min", (first_v >= DIM*DIM*DIM+3) ? 1 : 0, 1);
    check_eq("first_valid_max", (first_v >= 0 && first_v <= DIM*DIM*DIM+5) ? 1 : 0, 1);
    if (pat == 0) check_eq("zero_bubble", last_hs - first_v, SZ-1);
    check_eq("done_pulse", done, 1);
    check_eq("valid_drop", axis.m00_axis_tvalid, 0);
    check_eq("ovf", ovf, ovf_e);
    axis.m00_axis_tready = 1'b0;
    @(negedge clk);
    check_eq("done_single", done, 0);
    check_eq("back_to_load", axis.s00_axis_tready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // kind: 0 = small values, 1 = full byte range
  task automatic fill_rand(input int kind);
    for (int i = 0; i < SZ; i++) begin
      a_m[i] = (kind == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      b_m[i] = (kind == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
    end
  endtask

  initial begin
    int seen;
    axis.s00_axis_tvalid = 1'b0;
    axis.s00_axis_tlast  = 1'b0;
    axis.s00_axis_tdata  = 8'd0;
    axis.m00_axis_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_tready", axis.s00_axis_tready, 1);
    check_eq("rst_tvalid", axis.m00_axis_tvalid, 0);
    check_eq("rst_tlast", axis.m00_axis_tlast, 0);
    check_eq("rst_tdata", axis.m00_axis_tdata, 0);
    check_eq("rst_tstrb", axis.m00_axis_tstrb, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // 2x2 example embedded in the top-left corner of a 3x3.
    a_m = '{1, 2, 0, 3, 4, 0, 0, 0, 0};
    b_m = '{5, 6, 0, 7, 8, 0, 0, 0, 0};
    load_ab(1'b1, 1'b0);
    run_mult(1'b0, 0);

    // -I times 1..9, signed.
    a_m = '{255, 0, 0, 0, 255, 0, 0, 0, 255};
    b_m = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    load_ab(1'b1, 1'b0);
    run_mult(1'b1, 0);

    for (int i = 0; i < SZ; i++) begin a_m[i] = 100; b_m[i] = 100; end
    load_ab(1'b1, 1'b0);
    run_mult(1'b1, 0);
    load_ab(1'b1, 1'b0);
    run_mult(1'b0, 0);

    fill_rand(0);
    load_ab(1'b1, 1'b0);
    run_mult(1'b0, 1);

    for (int r = 0; r < 6; r++) begin
      fill_rand(r % 2);
      load_ab(1'b1, 1'b0);
      run_mult(1'($urandom_range(0, 1)), 2);
    end

    // start coinciding with the last B word is ignored.
    fill_rand(1);
    load_ab(1'b1, 1'b1);
    seen = 0;
    axis.m00_axis_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (axis.m00_axis_tvalid) seen++;
      @(negedge clk);
    end
    axis.m00_axis_tready = 1'b0;
    check_eq("early_start_ignored", seen, 0);
    run_mult(1'b1, 0);

    // Missing tlast on the last B word.
    fill_rand(0);
    load_ab(1'b0, 1'b0);
    check_eq("b_missing_last_err", err, 1);
    check_eq("b_missing_last_load", axis.s00_axis_tready, 1);
    do_reset();
    check_eq("err_cleared_by_rst", err, 0);

    // tlast on A word 2, then a correct reload.
    for (int i = 0; i < 3; i++) send_word($urandom_range(0, 255), i == 2, 1'b0);
    check_eq("a_tlast_err", err, 1);
    check_eq("a_tlast_load", axis.s00_axis_tready, 1);
    fill_rand(1);
    load_ab(1'b1, 1'b0);
    run_mult(1'b0, 2);
    check_eq("err_sticky", err, 1);

    // Reset in the middle of COMPUTE.
    do_reset();
    fill_rand(1);
    load_ab(1'b1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_tready", axis.s00_axis_tready, 1);
    check_eq("midrst_tvalid", axis.m00_axis_tvalid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset while a result is stalled on the output.
    fill_rand(0);
    load_ab(1'b1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    while (!axis.m00_axis_tvalid && seen < 60) begin
      @(negedge clk);
      seen++;
    end
    check_eq("stalled_valid_seen", axis.m00_axis_tvalid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("outrst_tvalid", axis.m00_axis_tvalid, 0);
    check_eq("outrst_tready", axis.s00_axis_tready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    fill_rand(1);
    load_ab(1'b1, 1'b0);
    run_mult(1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mat_mul_sat.md
Name: mat_mul_sat

Overview:
- Parametrised successor to the team's AXI-Stream matrix multiplier. Computes R = A x B for square DIM x DIM matrices.
- DIM is any integer >= 2; power of two not required.
- Supports signed/unsigned operands, a wide accumulator, and saturating write-back.
- A and B are loaded back-to-back over one input stream. R is returned over an output stream with full backpressure.
- Sits between the PS DMA (AXI-Stream) and AXI-Lite control registers.

Parameters:
DIM, 4, matrix dimension (>= 2)
DATA_WIDTH, 32, element width of A, B and R
ACC_WIDTH, 2*DATA_WIDTH+8, accumulator width (must be >= 2*DATA_WIDTH)
SIZE, DIM*DIM, elements per matrix (derived)
ADDR_W, clog2(SIZE), BRAM address width (derived)

Ports:
s00_axi_aclk  in  1  clock
s00_axi_areset  in  1  asynchronous active-high reset
s00_axis_tready  out  1  input stream ready
s00_axis_tvalid  in  1  input stream valid
s00_axis_tlast  in  1  input stream last
s00_axis_tdata  in  DATA_WIDTH  input element
m00_axis_tready  in  1  output stream ready
m00_axis_tvalid  out  1  output stream valid
m00_axis_tlast  out  1  last result element
m00_axis_tdata  out  DATA_WIDTH  result element
m00_axis_tstrb  out  DATA_WIDTH/8  constant all ones
start  in  1  one-cycle pulse from AXI-Lite; begins multiply
signed_mode  in  1  1 = two's-complement operands; sampled at start
done  out  1  one-cycle pulse when the last R element handshakes
ovf  out  1  sticky: some R element was saturated; cleared at start
err  out  1  sticky: framing error; cleared by reset only

Behaviour:
- Clock/reset: one clock, s00_axi_aclk. Reset is asynchronous and active-high on s00_axi_areset.
- Reset values:
  - State = LOAD_A; load counter = 0.
  - s00_axis_tready = 1; m00_axis_tvalid = 0; m00_axis_tlast = 0; m00_axis_tdata = 0.
  - done = 0; ovf = 0; err = 0.
  - Memory contents undefined.
- States: LOAD_A, LOAD_B, READY, COMPUTE, OUTPUT.
- LOAD_A / LOAD_B:
  - tready = 1. Each handshake writes mem[load_cnt] and increments load_cnt.
  - After SIZE words in LOAD_A: go to LOAD_B and clear load_cnt.
  - After SIZE words in LOAD_B: go to READY.
  - tlast must coincide with word SIZE-1 of B. If tlast arrives on any other word, or is missing on that word: set err, return to LOAD_A, clear load_cnt. The word itself is still written.
- READY: tready = 0. On start, latch signed_mode, clear ovf, go to COMPUTE. start in any other state is ignored.
- COMPUTE:
  - Loop order is row (outer), col, k (inner). One MAC issued per cycle.
  - Pipeline, 3 stages:
    - stage 1: address A[row*DIM+k], B[k*DIM+col];
    - stage 2: registered BRAM read;
    - stage 3: acc <= (k==0 ? 0 : acc) + A*B.
  - Product is sign- or zero-extended to ACC_WIDTH per the latched mode.
  - When k = DIM-1 reaches stage 3, the result is saturated to DATA_WIDTH and written to R[row*DIM+col] one cycle later:
    - signed: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1];
    - unsigned: clamp to [0, 2^DATA_WIDTH-1].
  - Any clamp sets ovf.
  - COMPUTE lasts exactly DIM^3+3 cycles, then goes to OUTPUT.
  - Non-power-of-two DIM: counters wrap at DIM-1, not at 2^n.
- OUTPUT:
  - m00_axis_tvalid rises no later than 2 cycles after entering OUTPUT.
  - Elements are sent in order R[0]..R[SIZE-1].
  - tdata and tlast stay stable while tvalid=1 and tready=0.
  - Read-ahead is allowed, but no element may be skipped or duplicated under any tready pattern. Zero-bubble throughput is required when tready is held at 1.
  - tlast=1 only with R[SIZE-1].
  - On the handshake of R[SIZE-1]: pulse done, drop tvalid the next cycle, go to LOAD_A.
- Simultaneous events: start together with an input handshake in LOAD_B word SIZE-1 is ignored (state is not yet READY).
- Reset mid-operation: all state is abandoned immediately; tvalid drops asynchronously.
- Width rule: the accumulator never wraps for DIM <= 2^(ACC_WIDTH-2*DATA_WIDTH).

Test Plan:
- Basic: DIM=2, unsigned; stream A=1,2,3,4 and B=5,6,7,8 with tlast on 8; pulse start; tready=1 -> output 19,22,43,50; tlast on 50; done 1 cycle; ovf=0; zero bubbles.
- Signed, DIM=3: A = -I, B = 1..9 (row-major); signed_mode=1 -> output -1..-9; ovf=0.
- Saturation: DATA_WIDTH=8, DIM=2, signed; all elements 100 -> every output 127, ovf=1. Same inputs unsigned -> 255, ovf=1.
- Backpressure: DIM=3, tready toggling 1,0,0,1,... -> exactly 9 elements in order, each stable while stalled, tlast only on the 9th.
- Framing: tlast on A word 2 -> err=1, state returns to LOAD_A; a correct reload then computes normally with err still 1.
- Reset mid-COMPUTE: assert s00_axi_areset -> tvalid=0 and tready=1 immediately; a fresh load/start produces correct results.
